// File: rtl/text_renderer_pkg.sv
// Shared constants, sideband record and address helper for the text-mode pixel pipeline.
package text_pkg;

  localparam int TEXT_COLS     = 80;
  localparam int TEXT_ROWS_VIS = 30;
  localparam int TEXT_ROWS_BUF = 32;
  localparam int FONT_W        = 8;
  localparam int FONT_H        = 16;
  localparam int PIPE_LAT      = 5;
  localparam int CHAR_ADDR_W   = 12;

  // Per-pixel information that travels alongside the memory lookups.
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       vis;
    logic       cursor_hit;
    logic [3:0] glyph_row;
    logic [2:0] bit_sel;
  } sideband_t;

  // prow*80 + col built from shifts so no multiplier is inferred.
  function automatic logic [CHAR_ADDR_W-1:0] cell_addr(input logic [4:0] prow,
                                                       input logic [6:0] col);
    cell_addr = {1'b0, prow, 6'b000000} + {3'b000, prow, 4'b0000} + {5'b00000, col};
  endfunction

endpackage

// File: rtl/text_renderer_if.sv
// Read-port bundle connecting the renderer to character buffer, font ROM and palette.
interface text_renderer_if;
  import text_pkg::*;

  logic [CHAR_ADDR_W-1:0] char_addr;
  logic [15:0]            char_data;
  logic [11:0]            font_addr;
  logic [7:0]             font_data;
  logic [3:0]             pal_addr_fg;
  logic [3:0]             pal_addr_bg;
  logic [5:0]             pal_data_fg;
  logic [5:0]             pal_data_bg;

  // Renderer side: drives addresses, receives data one clock later.
  modport master (
    output char_addr, font_addr, pal_addr_fg, pal_addr_bg,
    input  char_data, font_data, pal_data_fg, pal_data_bg
  );

  // Memory side: receives addresses, returns data.
  modport slave (
    input  char_addr, font_addr, pal_addr_fg, pal_addr_bg,
    output char_data, font_data, pal_data_fg, pal_data_bg
  );

endinterface

// File: rtl/text_renderer_cursor_blink.sv
// Frame-rate housekeeping: vsync rising-edge detect, blink frame counter and phase,
// and the strobe that loads the renderer's shadow registers once per frame.
module cursor_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync_in,
  output logic shadow_load,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  logic             vs_r;
  logic             vs_d_r;
  logic             rise_s;
  logic [CNT_W-1:0] cnt_r;
  logic             phase_r;

  // Register vsync twice so the edge is detected on clean, registered copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_r   <= 1'b0;
      vs_d_r <= 1'b0;
    end else begin
      vs_r   <= vsync_in;
      vs_d_r <= vs_r;
    end
  end

  // One-cycle strobe on the rising edge of the registered vsync.
  always_comb begin
    rise_s = vs_r & ~vs_d_r;
  end

  // Count frames; toggle the blink phase when the count wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      phase_r <= 1'b1;
    end else if (rise_s) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r   <= '0;
        phase_r <= ~phase_r;
      end else begin
        cnt_r   <= cnt_r + 1'b1;
      end
    end
  end

  assign shadow_load = rise_s;
  assign blink_phase = phase_r;

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel pipeline: pixel coordinates -> character cell -> glyph row -> palette colour.
// Fixed five-clock latency; sync/active sideband is delayed to stay aligned with rgb_out.
module text_renderer
  import text_pkg::*;
#(
  parameter int BLINK_FRAMES     = 30,
  parameter int CURSOR_START_ROW = 14
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [4:0]  scroll_row,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        cursor_enable,
  text_renderer_if.master mem,
  output logic [5:0]  rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out
);

  localparam logic [3:0] CUR_ROW0 = 4'(CURSOR_START_ROW);
  localparam logic [6:0] COLS     = 7'(TEXT_COLS);

  logic        shadow_load_s;
  logic        blink_phase_s;

  logic [4:0]  scroll_sh_r;
  logic [6:0]  cur_col_sh_r;
  logic [4:0]  cur_row_sh_r;
  logic        cur_en_sh_r;

  logic [6:0]  col_s;
  logic [4:0]  srow_s;
  logic [4:0]  prow_s;
  logic [6:0]  addr_col_s;
  sideband_t   sb_in_s;
  sideband_t [PIPE_LAT:1] sb_r;

  logic [CHAR_ADDR_W-1:0] char_addr_r;
  logic [11:0] font_addr_r;
  logic [3:0]  pal_fg_r;
  logic [3:0]  pal_bg_r;

  logic        bit_s;
  logic        cur_s;
  logic [5:0]  pix_s;
  logic [5:0]  rgb_r;

  logic        unused_s;

  cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk         (clk),
    .reset_n     (reset_n),
    .vsync_in    (vsync_in),
    .shadow_load (shadow_load_s),
    .blink_phase (blink_phase_s)
  );

  // Capture scroll/cursor controls once per frame so mid-frame writes cannot tear the picture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scroll_sh_r  <= 5'd0;
      cur_col_sh_r <= 7'd0;
      cur_row_sh_r <= 5'd0;
      cur_en_sh_r  <= 1'b0;
    end else if (shadow_load_s) begin
      scroll_sh_r  <= scroll_row;
      cur_col_sh_r <= cursor_col;
      cur_row_sh_r <= cursor_row;
      cur_en_sh_r  <= cursor_enable;
    end
  end

  // Cell decode: screen cell, scrolled ring-buffer row and first-stage sideband.
  always_comb begin
    col_s  = pixel_x[9:3];
    srow_s = pixel_y[8:4];
    prow_s = srow_s + scroll_sh_r;
    if (col_s < COLS) begin
      addr_col_s = col_s;
    end else begin
      addr_col_s = 7'd0;
    end
    sb_in_s            = '0;
    sb_in_s.hsync      = hsync_in;
    sb_in_s.vsync      = vsync_in;
    sb_in_s.active     = video_active;
    sb_in_s.vis        = video_active & (col_s < COLS);
    sb_in_s.glyph_row  = pixel_y[3:0];
    sb_in_s.bit_sel    = pixel_x[2:0];
    // Cursor matches on screen row so scrolling never drags it along.
    sb_in_s.cursor_hit = cur_en_sh_r & (col_s == cur_col_sh_r) & (srow_s == cur_row_sh_r);
  end

  // Stage 1: character buffer address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      char_addr_r <= '0;
    end else begin
      char_addr_r <= cell_addr(prow_s, addr_col_s);
    end
  end

  // Sideband shift register matching the memory round trips.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_r <= '0;
    end else begin
      sb_r[1] <= sb_in_s;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        sb_r[i] <= sb_r[i-1];
      end
    end
  end

  // Stage 3: glyph row address and palette indices from the returned character word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      font_addr_r <= 12'd0;
      pal_fg_r    <= 4'd0;
      pal_bg_r    <= 4'd0;
    end else begin
      font_addr_r <= {mem.char_data[7:0], sb_r[2].glyph_row};
      pal_fg_r    <= mem.char_data[11:8];
      pal_bg_r    <= mem.char_data[15:12];
    end
  end

  // Pixel select: glyph bit, cursor underline inversion and blanking.
  always_comb begin
    bit_s = mem.font_data[3'd7 - sb_r[4].bit_sel];
    cur_s = sb_r[4].cursor_hit & blink_phase_s & (sb_r[4].glyph_row >= CUR_ROW0);
    if (sb_r[4].vis) begin
      if (bit_s ^ cur_s) begin
        pix_s = mem.pal_data_fg;
      end else begin
        pix_s = mem.pal_data_bg;
      end
    end else begin
      pix_s = 6'd0;
    end
  end

  // Stage 5: registered pixel colour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_r <= 6'd0;
    end else begin
      rgb_r <= pix_s;
    end
  end

  assign mem.char_addr   = char_addr_r;
  assign mem.font_addr   = font_addr_r;
  assign mem.pal_addr_fg = pal_fg_r;
  assign mem.pal_addr_bg = pal_bg_r;

  assign rgb_out    = rgb_r;
  assign hsync_out  = sb_r[PIPE_LAT].hsync;
  assign vsync_out  = sb_r[PIPE_LAT].vsync;
  assign active_out = sb_r[PIPE_LAT].active;

  // Bits carried to the last stage only for alignment; pixel_y[9] lies beyond the visible area.
  assign unused_s = ^{pixel_y[9], sb_r[PIPE_LAT].vis, sb_r[PIPE_LAT].cursor_hit,
                      sb_r[PIPE_LAT].glyph_row, sb_r[PIPE_LAT].bit_sel};

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: address mapping, glyph/palette path, blanking,
// sideband latency, reset flush, shadow registers and cursor blink.
module tb_text_renderer;

  localparam int BF = 2;

  logic       clk;
  logic       reset_n;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_active;
  logic       hsync_in;
  logic       vsync_in;
  logic [4:0] scroll_row;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       cursor_enable;
  logic [5:0] rgb_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       active_out;

  text_renderer_if mif ();

  text_renderer #(
    .BLINK_FRAMES     (BF),
    .CURSOR_START_ROW (14)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .video_active  (video_active),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .scroll_row    (scroll_row),
    .cursor_col    (cursor_col),
    .cursor_row    (cursor_row),
    .cursor_enable (cursor_enable),
    .mem           (mif.master),
    .rgb_out       (rgb_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .active_out    (active_out)
  );

  logic [15:0] char_mem [0:4095];
  logic [7:0]  font_mem [0:4095];
  logic [5:0]  pal      [0:15];

  int   n_vec = 0;
  int   n_bad = 0;
  int   m_cnt;
  logic m_phase;
  logic m_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories, one clock of latency each.
  always @(posedge clk) begin
    mif.char_data   <= char_mem[mif.char_addr];
    mif.font_data   <= font_mem[mif.font_addr];
    mif.pal_data_fg <= pal[mif.pal_addr_fg];
    mif.pal_data_bg <= pal[mif.pal_addr_bg];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic addr_check(input logic [9:0] x, input logic [9:0] y,
                            input logic [11:0] exp, input string tag);
    @(negedge clk);
    pixel_x = x; pixel_y = y; video_active = 1'b1;
    @(negedge clk);
    check(tag, 64'(mif.char_addr), 64'(exp));
    video_active = 1'b0;
  endtask

  task automatic pixel_check(input logic [9:0] x, input logic [9:0] y, input logic act,
                             input logic [5:0] exp, input string tag);
    @(negedge clk);
    pixel_x = x; pixel_y = y; video_active = act;
    @(negedge clk);
    video_active = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_early"}, 64'(rgb_out), 64'd0);
    @(negedge clk);
    check(tag, 64'(rgb_out), 64'(exp));
  endtask

  task automatic vsync_pulse(input string tag);
    int lat;
    @(negedge clk);
    vsync_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (vsync_out === 1'b1 && lat == 0) lat = k;
    end
    check(tag, 64'(lat), 64'd5);
    vsync_in = 1'b0;
    repeat (8) @(negedge clk);
    m_en = cursor_enable;
    if (m_cnt == BF - 1) begin
      m_cnt   = 0;
      m_phase = ~m_phase;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  initial begin
    logic [11:0] hs_pat;
    logic [11:0] act_pat;
    logic        inv;

    for (int i = 0; i < 4096; i++) begin
      char_mem[i] = 16'h1E41;
      font_mem[i] = 8'h00;
    end
    for (int r = 0; r < 16; r++) font_mem[{8'h41, 4'(r)}] = 8'h80;
    pal[0]  = 6'h00; pal[1]  = 6'h02; pal[2]  = 6'h08; pal[3]  = 6'h0A;
    pal[4]  = 6'h20; pal[5]  = 6'h22; pal[6]  = 6'h24; pal[7]  = 6'h2A;
    pal[8]  = 6'h15; pal[9]  = 6'h17; pal[10] = 6'h1D; pal[11] = 6'h1F;
    pal[12] = 6'h35; pal[13] = 6'h37; pal[14] = 6'h3D; pal[15] = 6'h3F;

    reset_n = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0; video_active = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; scroll_row = 5'd0;
    cursor_col = 7'd0; cursor_row = 5'd0; cursor_enable = 1'b0;
    m_cnt = 0; m_phase = 1'b1; m_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {mif.char_addr, mif.font_addr, mif.pal_addr_fg, mif.pal_addr_bg,
                            rgb_out, hsync_out, vsync_out, active_out}, 64'd0);
    reset_n = 1'b1;

    // Address mapping, no scroll
    addr_check(10'd8, 10'd16, 12'd81, "addr_x8_y16");
    addr_check(10'd639, 10'd479, 12'd2399, "addr_last_cell");

    // Glyph and palette path
    pixel_check(10'd0, 10'd0, 1'b1, pal[14], "glyph_x0_fg");
    pixel_check(10'd1, 10'd0, 1'b1, pal[1], "glyph_x1_bg");
    pixel_check(10'd7, 10'd5, 1'b1, pal[1], "glyph_x7_bg");

    // Blanking
    pixel_check(10'd0, 10'd0, 1'b0, 6'd0, "blank_inactive");
    pixel_check(10'd640, 10'd0, 1'b1, 6'd0, "blank_col80");

    // Sideband latency with col >= 80 so rgb stays blank
    hs_pat  = 12'b1011_0011_1010;
    act_pat = 12'b0110_1001_1101;
    pixel_x = 10'd640; pixel_y = 10'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 5) begin
        check("hsync_delay", 64'(hsync_out), 64'(hs_pat[i-5]));
        check("active_delay", 64'(active_out), 64'(act_pat[i-5]));
        check("rgb_blank", 64'(rgb_out), 64'd0);
      end
      hsync_in = hs_pat[i];
      video_active = act_pat[i];
    end
    @(negedge clk);
    hsync_in = 1'b0; video_active = 1'b0;
    repeat (6) @(negedge clk);

    // Reset asserted while a pixel is in flight
    pixel_x = 10'd0; pixel_y = 10'd0; video_active = 1'b1;
    @(negedge clk);
    video_active = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("font_addr_e3", 64'(mif.font_addr), 64'h410);
    #2 reset_n = 1'b0;
    #1 check("reset_midline", {mif.char_addr, mif.font_addr, mif.pal_addr_fg, mif.pal_addr_bg,
                               rgb_out, hsync_out, vsync_out, active_out}, 64'd0);
    m_cnt = 0; m_phase = 1'b1; m_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pixel_check(10'd0, 10'd0, 1'b1, pal[14], "after_reset_pixel");

    // Scroll 31: screen row 0 -> physical 31, screen row 1 -> physical 0
    scroll_row = 5'd31;
    vsync_pulse("vsync_lat_a");
    addr_check(10'd0, 10'd0, 12'd2480, "addr_scroll31_y0");
    addr_check(10'd0, 10'd16, 12'd0, "addr_scroll31_y16");

    // Shadow: mid-frame change has no effect until the next vsync
    scroll_row = 5'd0;
    addr_check(10'd0, 10'd0, 12'd2480, "shadow_hold");
    vsync_pulse("vsync_lat_b");
    addr_check(10'd0, 10'd0, 12'd0, "shadow_loaded");

    // Cursor at column 3, screen row 2, over four frames
    cursor_col = 7'd3; cursor_row = 5'd2; cursor_enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      vsync_pulse("vsync_lat_cur");
      inv = m_en & m_phase;
      pixel_check(10'd25, 10'd46, 1'b1, inv ? pal[14] : pal[1], "cursor_row14_bg");
      pixel_check(10'd24, 10'd47, 1'b1, inv ? pal[1] : pal[14], "cursor_row15_fg");
      pixel_check(10'd25, 10'd45, 1'b1, pal[1], "cursor_row13_plain");
      pixel_check(10'd33, 10'd46, 1'b1, pal[1], "cursor_next_col_plain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
